// File: rtl/div_seq_core_if.sv
// Operand-load / result bus for div_seq_core.
// Carries signed_mode only when DIV_SIGNED_EN is defined.
interface div_seq_core_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IN_W  = 16
);
  localparam int unsigned NCHUNK = WIDTH / IN_W;
  localparam int unsigned LIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [IN_W-1:0]   load_data;
  logic              load_sel;
  logic [LIDX_W-1:0] load_idx;
  logic              load_we;
  logic              start;
`ifdef DIV_SIGNED_EN
  logic              signed_mode;
`endif
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [WIDTH-1:0]  quotient;
  logic [WIDTH-1:0]  remainder;
  logic [WIDTH-1:0]  dividend_q;
  logic [WIDTH-1:0]  divisor_q;

  modport master (
`ifdef DIV_SIGNED_EN
    output signed_mode,
`endif
    output load_data, load_sel, load_idx, load_we, start,
    input  busy, done, div_by_zero, quotient, remainder, dividend_q, divisor_q
  );

  modport slave (
`ifdef DIV_SIGNED_EN
    input  signed_mode,
`endif
    input  load_data, load_sel, load_idx, load_we, start,
    output busy, done, div_by_zero, quotient, remainder, dividend_q, divisor_q
  );
endinterface

// File: rtl/div_seq_core.sv
// Iterative restoring divider with chunked operand loading and busy/done handshake.
// Optional signed mode is enabled by defining DIV_SIGNED_EN.
module div_seq_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  div_seq_core_if.slave    bus
);
  localparam int unsigned NCHUNK = WIDTH / IN_W;
  localparam int unsigned LIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CNT_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] wdiv_q, wdiv_d;

  logic [WIDTH:0]   shift_c, trial_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c, quot_fix_c, rem_fix_c;

  // One restoring step: partial remainder shifted with the next dividend bit.
  assign shift_c = {acc_q, wq_q[WIDTH-1]};
  assign trial_c = shift_c - {1'b0, wdiv_q};

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic sgn_a_c, sgn_b_c;

  assign sgn_a_c    = bus.signed_mode & dividend_q[WIDTH-1];
  assign sgn_b_c    = bus.signed_mode & divisor_q[WIDTH-1];
  assign mag_a_c    = sgn_a_c ? WIDTH'(0) - dividend_q : dividend_q;
  assign mag_b_c    = sgn_b_c ? WIDTH'(0) - divisor_q  : divisor_q;
  // Most-negative / -1 falls out naturally: 2^(W-1) negated wraps to itself.
  assign quot_fix_c = neg_quot_q ? WIDTH'(0) - wq_q  : wq_q;
  assign rem_fix_c  = neg_rem_q  ? WIDTH'(0) - acc_q : acc_q;
`else
  assign mag_a_c    = dividend_q;
  assign mag_b_c    = divisor_q;
  assign quot_fix_c = wq_q;
  assign rem_fix_c  = acc_q;
`endif

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    wq_d       = wq_q;
    wdiv_d     = wdiv_q;
`ifdef DIV_SIGNED_EN
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif

    if (state_q == S_IDLE && bus.load_we) begin
      for (int i = 0; i < int'(NCHUNK); i++) begin
        if (bus.load_idx == LIDX_W'(i)) begin
          if (bus.load_sel) divisor_d[i*IN_W +: IN_W]  = bus.load_data;
          else              dividend_d[i*IN_W +: IN_W] = bus.load_data;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (divisor_q == '0) begin
            state_d = S_FIN;
            dbz_d   = 1'b1;
            quot_d  = '1;
            rem_d   = dividend_q;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            dbz_d   = 1'b0;
            cnt_d   = CNT_W'(WIDTH - 1);
            acc_d   = '0;
            wq_d    = mag_a_c;
            wdiv_d  = mag_b_c;
`ifdef DIV_SIGNED_EN
            neg_quot_d = sgn_a_c ^ sgn_b_c;
            neg_rem_d  = sgn_a_c;
`endif
          end
        end
      end
      S_RUN: begin
        if (!trial_c[WIDTH]) acc_d = trial_c[WIDTH-1:0];
        else                 acc_d = shift_c[WIDTH-1:0];
        wq_d = {wq_q[WIDTH-2:0], ~trial_c[WIDTH]};
        if (cnt_q == '0) state_d = S_FIN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!dbz_q) begin
          quot_d = quot_fix_c;
          rem_d  = rem_fix_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      wq_q       <= '0;
      wdiv_q     <= '0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      wq_q       <= wq_d;
      wdiv_q     <= wdiv_d;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.dividend_q  = dividend_q;
  assign bus.divisor_q   = divisor_q;
endmodule

// File: tb/tb_div_seq_core.sv
// Self-checking bench for div_seq_core: vector table, corner sequences, random vs. arithmetic model.
module tb_div_seq_core;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_seq_core_if #(.WIDTH(W), .IN_W(IW)) dif ();
  div_seq_core #(.WIDTH(W), .IN_W(IW)) dut (.clk(clk), .rst(rst_n), .bus(dif));

  // Three-chunk instance so an out-of-range chunk index is expressible.
  div_seq_core_if #(.WIDTH(24), .IN_W(8)) dif3 ();
  div_seq_core #(.WIDTH(24), .IN_W(8)) dut3 (.clk(clk), .rst(rst_n), .bus(dif3));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic from the divider rules.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sm,
                                  output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
    end else begin
      dbz = 1'b0;
      if (sm) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000; r = 32'd0;
        end else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic wr(input logic sel, input logic idx, input logic [15:0] d);
    dif.load_sel  = sel;
    dif.load_idx  = idx;
    dif.load_data = d;
    dif.load_we   = 1'b1;
    @(negedge clk);
    dif.load_we   = 1'b0;
  endtask

  task automatic wr3(input logic sel, input logic [1:0] idx, input logic [7:0] d);
    dif3.load_sel  = sel;
    dif3.load_idx  = idx;
    dif3.load_data = d;
    dif3.load_we   = 1'b1;
    @(negedge clk);
    dif3.load_we   = 1'b0;
  endtask

  task automatic load_ops(input logic [31:0] a, input logic [31:0] b);
    wr(1'b0, 1'b1, a[31:16]);
    wr(1'b0, 1'b0, a[15:0]);
    wr(1'b1, 1'b1, b[31:16]);
    wr(1'b1, 1'b0, b[15:0]);
  endtask

  // Called just after the negedge following the start edge; lat = edges until done seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (dif.done !== 1'b1 && lat < 100) begin
      if (dif.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] qe, input logic [31:0] re, input logic dbze);
    int lat, bcnt;
    load_ops(a, b);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done(lat, bcnt);
    check({tag, ".lat"}, 64'(lat), dbze ? 64'd1 : 64'(W + 1));
    check({tag, ".busy"}, 64'(bcnt), dbze ? 64'd0 : 64'(W + 1));
    check({tag, ".q"}, 64'(dif.quotient), 64'(qe));
    check({tag, ".r"}, 64'(dif.remainder), 64'(re));
    check({tag, ".dbz"}, 64'(dif.div_by_zero), 64'(dbze));
    @(negedge clk);
    check({tag, ".pulse"}, 64'(dif.done), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int lat, bcnt, lat2, bcnt2;
    logic seen;
    logic [31:0] a, b, qe, re;
    logic dbze;

    dif.load_data = '0; dif.load_sel = 1'b0; dif.load_idx = '0; dif.load_we = 1'b0; dif.start = 1'b0;
    dif3.load_data = '0; dif3.load_sel = 1'b0; dif3.load_idx = '0; dif3.load_we = 1'b0; dif3.start = 1'b0;
`ifdef DIV_SIGNED_EN
    dif.signed_mode  = 1'b0;
    dif3.signed_mode = 1'b0;
`endif

    vecs.push_back('{"d100_7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
    vecs.push_back('{"dbz55",    32'h55,         32'd0,          32'hFFFF_FFFF,  32'h55,         1'b1});
    vecs.push_back('{"d55_3",    32'h55,         32'd3,          32'h1C,         32'd1,          1'b0});
    vecs.push_back('{"dmax_16",  32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0});
    vecs.push_back('{"dmax_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
    vecs.push_back('{"d5_10",    32'd5,          32'd10,         32'd0,          32'd5,          1'b0});
    vecs.push_back('{"d0_5",     32'd0,          32'd5,          32'd0,          32'd0,          1'b0});
    vecs.push_back('{"dmsb_1",   32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{"dbig_div", 32'hFFFF_FFFE,  32'h8000_0001,  32'd1,          32'h7FFF_FFFD,  1'b0});

    // Reset state
    @(negedge clk);
    check("rst.busy", 64'(dif.busy), 64'd0);
    check("rst.done", 64'(dif.done), 64'd0);
    check("rst.dbz", 64'(dif.div_by_zero), 64'd0);
    check("rst.q", 64'(dif.quotient), 64'd0);
    check("rst.r", 64'(dif.remainder), 64'd0);
    check("rst.dividend", 64'(dif.dividend_q), 64'd0);
    check("rst.divisor", 64'(dif.divisor_q), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Chunk loading
    wr(1'b0, 1'b1, 16'h1234);
    wr(1'b0, 1'b0, 16'h5678);
    check("load.dividend", 64'(dif.dividend_q), 64'h1234_5678);
    wr(1'b1, 1'b1, 16'hBEEF);
    check("load.divisor_hi", 64'(dif.divisor_q), 64'hBEEF_0000);
    wr3(1'b0, 2'd0, 8'h56);
    wr3(1'b0, 2'd1, 8'h34);
    wr3(1'b0, 2'd2, 8'h12);
    check("load3.dividend", 64'(dif3.dividend_q), 64'h12_3456);
    wr3(1'b0, 2'd3, 8'hFF);
    check("load3.bad_idx", 64'(dif3.dividend_q), 64'h12_3456);
    wr3(1'b1, 2'd1, 8'hAB);
    check("load3.divisor", 64'(dif3.divisor_q), 64'h00_AB00);

    // Vector table
    foreach (vecs[i]) do_div(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

    // Start and load_we mid-RUN are ignored
    load_ops(32'hFFFF_FFFF, 32'h10);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (5) @(negedge clk);
    dif.start = 1'b1; dif.load_sel = 1'b0; dif.load_idx = 1'b0; dif.load_data = 16'h1111; dif.load_we = 1'b1;
    @(negedge clk);
    dif.start = 1'b0; dif.load_we = 1'b0;
    wait_done(lat, bcnt);
    check("busyprot.lat", 64'(lat + 6), 64'(W + 1));
    check("busyprot.q", 64'(dif.quotient), 64'h0FFF_FFFF);
    check("busyprot.r", 64'(dif.remainder), 64'hF);
    check("busyprot.dividend", 64'(dif.dividend_q), 64'hFFFF_FFFF);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (dif.busy === 1'b1 || dif.done === 1'b1) seen = 1'b1; end
    check("busyprot.no_queue", 64'(seen), 64'd0);

    // Snapshot ignores same-edge divisor write, which still lands in the register
    load_ops(32'd100, 32'd7);
    dif.start = 1'b1; dif.load_sel = 1'b1; dif.load_idx = 1'b0; dif.load_data = 16'h0; dif.load_we = 1'b1;
    @(negedge clk);
    dif.start = 1'b0; dif.load_we = 1'b0;
    wait_done(lat, bcnt);
    check("snap.lat", 64'(lat), 64'(W + 1));
    check("snap.q", 64'(dif.quotient), 64'd14);
    check("snap.r", 64'(dif.remainder), 64'd2);
    check("snap.divisor", 64'(dif.divisor_q), 64'd0);

    // Reset mid-RUN
    load_ops(32'd1000, 32'd9);
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 64'(dif.busy), 64'd0);
    check("midrst.dbz", 64'(dif.div_by_zero), 64'd0);
    check("midrst.q", 64'(dif.quotient), 64'd0);
    check("midrst.r", 64'(dif.remainder), 64'd0);
    check("midrst.dividend", 64'(dif.dividend_q), 64'd0);
    check("midrst.divisor", 64'(dif.divisor_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (dif.done === 1'b1) seen = 1'b1; end
    check("midrst.no_done", 64'(seen), 64'd0);
    do_div("postrst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

    // Start held high: back-to-back operations
    load_ops(32'd100, 32'd7);
    dif.start = 1'b1;
    @(negedge clk);
    wait_done(lat, bcnt);
    @(negedge clk);
    wait_done(lat2, bcnt2);
    dif.start = 1'b0;
    check("b2b.lat1", 64'(lat), 64'(W + 1));
    check("b2b.lat2", 64'(lat2), 64'(W + 1));
    check("b2b.busy2", 64'(bcnt2), 64'(W + 1));
    check("b2b.q", 64'(dif.quotient), 64'd14);
    @(negedge clk);

    // Random unsigned vs. model
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 255));
        2: b = (i % 8 == 2) ? 32'd0 : a >> $urandom_range(0, 31);
        default: b = 32'($urandom_range(0, 3));
      endcase
      ref_div(a, b, 1'b0, qe, re, dbze);
      do_div($sformatf("rnd%0d", i), a, b, qe, re, dbze);
    end

`ifdef DIV_SIGNED_EN
    dif.signed_mode = 1'b1;
    do_div("s_neg7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do_div("s_dbz", 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    do_div("s_7_neg2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : 32'(32'sd0 - 32'($urandom_range(1, 100)));
      ref_div(a, b, 1'b1, qe, re, dbze);
      do_div($sformatf("srnd%0d", i), a, b, qe, re, dbze);
    end
    dif.signed_mode = 1'b0;
    do_div("u_after_s", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
